// File: rtl/ptosda_tx.sv
// ptosda_tx - parallel-to-serial transmitter for the two-wire scl/sda link
// that feeds the 4-bit-to-16-line one-hot decoder.
//
// A 4-bit code accepted on the din/din_valid/din_ready handshake becomes one
// frame: setup (S0), start (S1), four data bits MSB first (L/H phase pairs),
// then P0/P1 and the stop edge (P2). Every phase lasts TICK_DIV clk cycles.
// scl and sda are registered and derived from the *next* state, so each
// output changes exactly on a phase boundary.
//
// Optional build macro: PTOSDA_PARITY_EN inserts an even-parity bit (phases
// PL/PH) between the last data bit and P0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   din        code to transmit, sampled on accept
//   din_valid  din holds a code to send
//   din_ready  block can accept a code this cycle
//   scl        serial clock line (a data signal here, not a clock)
//   sda        serial data line
//   busy       frame in progress
//   done       one-cycle pulse when the frame ends
module ptosda_tx #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       scl,
  output logic       sda,
  output logic       busy,
  output logic       done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [4:0] {
    IDLE, S0, S1,
    B3L, B3H, B2L, B2H, B1L, B1H, B0L, B0H,
`ifdef PTOSDA_PARITY_EN
    PL, PH,
`endif
    P0, P1, P2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      shift_q, shift_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef PTOSDA_PARITY_EN
  logic            par_q, par_d;
`endif

  function automatic state_t next_phase(input state_t s);
    case (s)
      S0:      return S1;
      S1:      return B3L;
      B3L:     return B3H;
      B3H:     return B2L;
      B2L:     return B2H;
      B2H:     return B1L;
      B1L:     return B1H;
      B1H:     return B0L;
      B0L:     return B0H;
`ifdef PTOSDA_PARITY_EN
      B0H:     return PL;
      PL:      return PH;
      PH:      return P0;
`else
      B0H:     return P0;
`endif
      P0:      return P1;
      P1:      return P2;
      default: return IDLE;
    endcase
  endfunction

  logic phase_end;
  assign phase_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef PTOSDA_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q == IDLE) begin
      if (din_valid && ready_q) begin
        state_d = S0;
        cnt_d   = '0;
        shift_d = din;
`ifdef PTOSDA_PARITY_EN
        par_d   = ^din;
`endif
      end
    end else if (phase_end) begin
      cnt_d   = '0;
      state_d = next_phase(state_q);
      // Move the next bit into shift_q[3] as scl falls into the next L phase.
      if (state_q == B3H || state_q == B2H || state_q == B1H)
        shift_d = {shift_q[2:0], 1'b0};
      if (state_q == P2)
        done_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Line levels follow the state being entered so they are registered
    // together with it; sda only moves with scl high at S1 and P2 entry.
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      S1:                     begin scl_d = 1'b1; sda_d = 1'b0;       end
      B3L, B2L, B1L, B0L:     begin scl_d = 1'b0; sda_d = shift_d[3]; end
      B3H, B2H, B1H, B0H:     begin scl_d = 1'b1; sda_d = shift_d[3]; end
`ifdef PTOSDA_PARITY_EN
      PL:                     begin scl_d = 1'b0; sda_d = par_q;      end
      PH:                     begin scl_d = 1'b1; sda_d = par_q;      end
`endif
      P0:                     begin scl_d = 1'b0; sda_d = 1'b0;       end
      P1:                     begin scl_d = 1'b1; sda_d = 1'b0;       end
      default:                begin scl_d = 1'b1; sda_d = 1'b1;       end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PTOSDA_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PTOSDA_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign din_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign scl       = scl_q;
  assign sda       = sda_q;

endmodule
